// File: rtl/axi4_mem_slave.sv
// AXI4 burst-capable memory slave: register-array memory behind independent read and write FSMs.
// IDs are echoed; malformed requests get SLVERR and out-of-range beats get DECERR.
module axi4_mem_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [7:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [1:0]              awburst_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [7:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [1:0]              arburst_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o
);
    localparam int unsigned STRB = DATA_WIDTH / 8;
    localparam int unsigned SZW  = $clog2(STRB);
    localparam int unsigned IDXW = $clog2(MEM_WORDS);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic {RIdle, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    function automatic logic req_bad(logic [2:0] size, logic [7:0] len, logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (32'(size) > SZW) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic addr_t next_addr(addr_t addr, logic [2:0] size, logic [7:0] len,
                                        logic [1:0] burst);
        addr_t step;
        addr_t mask;
        step = addr_t'(1) << size;
        mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + step) & mask);
            default: return addr + step;
        endcase
    endfunction

    function automatic logic in_range(addr_t addr);
        addr_t off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> SZW) < addr_t'(MEM_WORDS));
    endfunction

    function automatic logic [IDXW-1:0] word_idx(addr_t addr);
        addr_t off;
        off = addr - BASE_ADDR;
        return off[SZW +: IDXW];
    endfunction

    function automatic logic [1:0] worst(logic [1:0] a, logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // Write channel state
    w_state_e            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] wid_q, wid_d, bid_q, bid_d;
    addr_t               waddr_q, waddr_d;
    logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]          wsize_q, wsize_d;
    logic [1:0]          wburst_q, wburst_d, wacc_q, wacc_d, bresp_q, bresp_d, w_acc;
    logic                wbad_q, wbad_d, wabsorb_q, wabsorb_d, bvalid_q, bvalid_d;
    logic                mem_we, w_in_range;
    logic [IDXW-1:0]     mem_widx;

    always_comb begin
        w_state_d  = w_state_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        wbad_d     = wbad_q;
        wcnt_d     = wcnt_q;
        wacc_d     = wacc_q;
        wabsorb_d  = wabsorb_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        w_acc      = wacc_q;
        mem_we     = 1'b0;
        w_in_range = in_range(waddr_q);
        mem_widx   = word_idx(waddr_q);
        unique case (w_state_q)
            WIdle: begin
                if (awvalid_i) begin
                    w_state_d = WData;
                    wid_d     = awid_i;
                    waddr_d   = awaddr_i;
                    wlen_d    = awlen_i;
                    wsize_d   = awsize_i;
                    wburst_d  = awburst_i;
                    wbad_d    = req_bad(awsize_i, awlen_i, awburst_i);
                    wcnt_d    = 8'd0;
                    wacc_d    = req_bad(awsize_i, awlen_i, awburst_i) ? RespSlvErr : RespOkay;
                    wabsorb_d = 1'b0;
                end
            end
            WData: begin
                if (wvalid_i) begin
                    if (!wabsorb_q) begin
                        mem_we = !wbad_q && w_in_range;
                        if (!wbad_q && !w_in_range) w_acc = worst(w_acc, RespDecErr);
                    end
                    if (wabsorb_q) begin
                        if (wlast_i) w_state_d = WResp;
                    end else if (wlast_i) begin
                        if (wcnt_q != wlen_q) w_acc = worst(w_acc, RespSlvErr);
                        w_state_d = WResp;
                    end else if (wcnt_q == wlen_q) begin
                        // Missing wlast: soak up the extra beats without writing them.
                        w_acc     = worst(w_acc, RespSlvErr);
                        wabsorb_d = 1'b1;
                    end else begin
                        waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                        wcnt_d  = wcnt_q + 8'd1;
                    end
                    wacc_d = w_acc;
                    if (w_state_d == WResp) begin
                        bvalid_d = 1'b1;
                        bid_d    = wid_q;
                        bresp_d  = w_acc;
                    end
                end
            end
            WResp: begin
                if (bready_i) begin
                    bvalid_d  = 1'b0;
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_state_q <= WIdle;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbad_q    <= 1'b0;
            wcnt_q    <= '0;
            wacc_q    <= RespOkay;
            wabsorb_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbad_q    <= wbad_d;
            wcnt_q    <= wcnt_d;
            wacc_q    <= wacc_d;
            wabsorb_q <= wabsorb_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < STRB; b++) begin
                if (wstrb_i[b]) mem_q[mem_widx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Read channel state
    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    addr_t                 raddr_q, raddr_d, rd_addr;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d, rd_resp;
    logic                  rbad_q, rbad_d, rvalid_q, rvalid_d, rlast_q, rlast_d, rd_bad, rd_ok;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
    logic [IDXW-1:0]       rd_idx;

    // The beat loaded this cycle is presented next cycle, so forward a coincident write into it.
    always_comb begin
        rd_addr = (r_state_q == RIdle) ? araddr_i
                                       : next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
        rd_bad  = (r_state_q == RIdle) ? req_bad(arsize_i, arlen_i, arburst_i) : rbad_q;
        rd_idx  = word_idx(rd_addr);
        rd_word = mem_q[rd_idx];
        for (int b = 0; b < STRB; b++) begin
            if (mem_we && (mem_widx == rd_idx) && wstrb_i[b]) rd_word[8*b +: 8] = wdata_i[8*b +: 8];
        end
        rd_ok   = !rd_bad && in_range(rd_addr);
        rd_resp = rd_bad ? RespSlvErr : (rd_ok ? RespOkay : RespDecErr);
    end

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbad_d    = rbad_q;
        rcnt_d    = rcnt_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        unique case (r_state_q)
            RIdle: begin
                if (arvalid_i) begin
                    r_state_d = RData;
                    rid_d     = arid_i;
                    raddr_d   = araddr_i;
                    rlen_d    = arlen_i;
                    rsize_d   = arsize_i;
                    rburst_d  = arburst_i;
                    rbad_d    = rd_bad;
                    rcnt_d    = 8'd0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_ok ? rd_word : '0;
                    rresp_d   = rd_resp;
                    rlast_d   = (arlen_i == 8'd0);
                end
            end
            RData: begin
                if (rready_i) begin
                    if (rlast_q) begin
                        r_state_d = RIdle;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        raddr_d = rd_addr;
                        rcnt_d  = rcnt_q + 8'd1;
                        rdata_d = rd_ok ? rd_word : '0;
                        rresp_d = rd_resp;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state_q <= RIdle;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbad_q    <= 1'b0;
            rcnt_q    <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbad_q    <= rbad_d;
            rcnt_q    <= rcnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Address readies are forced low while reset is asserted.
    assign awready_o = rst_i && (w_state_q == WIdle);
    assign wready_o  = (w_state_q == WData);
    assign bvalid_o  = bvalid_q;
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = rst_i && (r_state_q == RIdle);
    assign rvalid_o  = rvalid_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;

endmodule
